// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add MULT/MULTU and restoring DIV/DIVU,
// one bit per clock, with results held in HI/LO until the next completion.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t             state_r, state_s;
  logic               is_div_r, sign_a_r, sign_b_r;
  logic [WIDTH-1:0]   a_orig_r, mag_a_r, mag_b_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;

  logic               sign_a_s, sign_b_s, last_iter_s, div_ok_s, div_zero_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, div_diff_s, quo_s, rem_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_s;

  // Next-state logic for the IDLE -> RUN -> FIX sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_iter_s) state_s = FIX;
        else             state_s = RUN;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Operand magnitudes, per-iteration steps and final sign correction
  always_comb begin
    sign_a_s    = op[0] & operand_a[WIDTH-1];
    sign_b_s    = op[0] & operand_b[WIDTH-1];
    mag_a_s     = sign_a_s ? -operand_a : operand_a;
    mag_b_s     = sign_b_s ? -operand_b : operand_b;
    last_iter_s = (cnt_r == CW'(WIDTH-1));
    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    // Divide: acc = {remainder, dividend/quotient}, shifted left.
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_ok_s    = (div_shift_s >= {1'b0, mag_b_r});
    div_diff_s  = div_shift_s[WIDTH-1:0] - mag_b_r;
    div_next_s  = div_ok_s ? {div_diff_s, acc_r[WIDTH-2:0], 1'b1}
                           : {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    prod_s      = (sign_a_r ^ sign_b_r) ? -acc_r : acc_r;
    quo_s       = (sign_a_r ^ sign_b_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s       = sign_a_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    div_zero_s  = (mag_b_r == {WIDTH{1'b0}});
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_r    <= 1'b0;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      a_orig_r    <= {WIDTH{1'b0}};
      mag_a_r     <= {WIDTH{1'b0}};
      mag_b_r     <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      done <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (start) begin
            is_div_r <= op[1];
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            a_orig_r <= operand_a;
            mag_a_r  <= mag_a_s;
            mag_b_r  <= mag_b_s;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {{WIDTH{1'b0}}, (op[1] ? mag_a_s : mag_b_s)};
          end
        end
        RUN: begin
          cnt_r <= cnt_r + CW'(1);
          acc_r <= is_div_r ? div_next_s : mul_next_s;
        end
        FIX: begin
          if (is_div_r) begin
            // Divide by zero reports all-ones quotient and the original dividend.
            if (div_zero_s) begin
              lo <= {WIDTH{1'b1}};
              hi <= a_orig_r;
            end else begin
              lo <= quo_s;
              hi <= rem_s;
            end
            div_by_zero <= div_zero_s;
          end else begin
            hi          <= prod_s[2*WIDTH-1:WIDTH];
            lo          <= prod_s[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO/div_by_zero and start cycle
// are queued at issue and checked when done pulses.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] operand_a, operand_b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           start_cyc;
  } exp_t;

  exp_t scoreboard[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic prev_done = 1'b0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {div_by_zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'b00: begin
        p = {32'h0, a} * {32'h0, b};
        return {1'b0, p};
      end
      2'b01: begin
        q = sa * sbv;
        return {1'b0, q[63:0]};
      end
      2'b10: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Output monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (prev_done) check("done_width", done, 0);
    prev_done = (done === 1'b1);
    if (done === 1'b1) begin
      check("busy_with_done", busy, 0);
      if (scoreboard.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        cur = scoreboard.pop_front();
        check("hi", hi, cur.hi);
        check("lo", lo, cur.lo);
        check("div_by_zero", div_by_zero, cur.dbz);
        // cyc moves from N (before start edge) to N+34 after edge E+33
        check("latency", cyc - cur.start_cyc, 34);
      end
    end
  end

  // Called at a falling edge; start is accepted at the next rising edge
  task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] m;
    m = model(o, a, b);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    scoreboard.push_back('{hi: m[63:32], lo: m[31:0], dbz: m[64], start_cyc: cyc});
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    push_exp(o, a, b);
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic drain();
    int k = 0;
    while (scoreboard.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", scoreboard.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 2'b00;
    operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0;
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_dbz", div_by_zero, 0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);         drain();
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);         drain();
    issue(2'b10, 32'd100, 32'd0);               drain();
    issue(2'b00, 32'd6, 32'd7);                 drain();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); drain();
    issue(2'b11, 32'hFFFF_FF9C, 32'd0);         drain();

    // Start pulse while busy must be ignored
    issue(2'b10, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    check("busy_mid_run", busy, 1);
    op = 2'b00; operand_a = 32'd5; operand_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of a MULT aborts it without a done pulse
    op = 2'b01; operand_a = 32'hFFFF_FFFB; operand_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_dbz", div_by_zero, 0);
    repeat (40) @(negedge clk);
    issue(2'b01, 32'd12345, 32'hFFFF_FD5A); drain();

    for (int i = 0; i < 6; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'd0 : $urandom);
      drain();
    end

    // Back-to-back: start held high through the done cycle
    push_exp(2'b01, 32'h7FFF_FFFF, 32'h8000_0000);
    begin
      int k = 0;
      while (done !== 1'b1 && k < 60) begin
        @(negedge clk);
        k++;
      end
      check("b2b_first_done", done, 1);
    end
    push_exp(2'b11, 32'hFFFF_FC18, 32'd7);
    @(negedge clk);
    start = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
